// File: rtl/test_pattern_checker.sv
// -----------------------------------------------------------------------------
// test_pattern_checker
//
// Receive-side checker for the interlaced test pattern stream. It rebuilds the
// expected H/V/field counters from the incoming SOF markers and flags every
// pixel that breaks the pattern R = H, B = V, G = V + F + H (all mod 256).
// It reports lock status, per-pixel errors, sync errors and a saturating
// error total for bring-up and soak testing.
//
// Parameters
//   H_TOTAL    pixels per line (expected H wraps H_TOTAL-1 -> 0)
//   V_TOTAL    lines per field (expected V wraps V_TOTAL-1 -> 0)
//   ERR_LIMIT  mismatched pixels in one locked field that force loss of lock
//
// Ports
//   CK_i          clock, rising edge
//   RST_i         synchronous active-high reset, wins over CK_EE_i
//   CK_EE_i       pixel enable; all state advances only when high
//   SOF_i         start-of-field marker, high with pixel (0,0)
//   R_i/G_i/B_i   8-bit pixel data
//   LOCK_o        high while the checker is in LOCK
//   ERR_o         one-enabled-cycle pulse per mismatching pixel
//   SYNC_ERR_o    one-enabled-cycle pulse on any SOF anomaly
//   FIELD_DONE_o  one-enabled-cycle pulse after the last pixel of a field
//   ERRCNT_o      mismatched pixels since reset, saturates at 0xFFFF
//   HEXP_o/VEXP_o expected H/V of the pixel just compared
//   FEXP_o        expected field counter of the pixel just compared
// -----------------------------------------------------------------------------
module test_pattern_checker #(
   parameter int H_TOTAL   = 910,
   parameter int V_TOTAL   = 262,
   parameter int ERR_LIMIT = 16
) (
   input  logic        CK_i,
   input  logic        RST_i,
   input  logic        CK_EE_i,
   input  logic        SOF_i,
   input  logic [7:0]  R_i,
   input  logic [7:0]  G_i,
   input  logic [7:0]  B_i,
   output logic        LOCK_o,
   output logic        ERR_o,
   output logic        SYNC_ERR_o,
   output logic        FIELD_DONE_o,
   output logic [15:0] ERRCNT_o,
   output logic [15:0] HEXP_o,
   output logic [15:0] VEXP_o,
   output logic [7:0]  FEXP_o
);

   localparam int FE_W = $clog2(ERR_LIMIT + 1);

   typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic [7:0]  f;
   } pos_t;

   // Raster position following p.
   function automatic pos_t advance(input pos_t p);
      pos_t n;
      n = p;
      if (p.h == 16'(H_TOTAL - 1)) begin
         n.h = '0;
         if (p.v == 16'(V_TOTAL - 1)) begin
            n.v = '0;
            n.f = p.f + 8'd1;
         end else begin
            n.v = p.v + 16'd1;
         end
      end else begin
         n.h = p.h + 16'd1;
      end
      return n;
   endfunction

   state_t          state_q, state_d;
   pos_t            pos_q, pos_d;   // expected position of the next pixel
   pos_t            exp_q, exp_d;   // expected position of the pixel just compared
   logic [FE_W-1:0] fe_q, fe_d, fe_inc;
   logic [15:0]     errcnt_q, errcnt_d;
   logic            lock_q, err_q, err_d, sync_q, sync_d, done_q, done_d;
   logic            acquire;

   logic       at_origin, at_last, mismatch, sof_clean;
   logic [7:0] g_exp;

   assign at_origin = (pos_q.h == 16'd0) && (pos_q.v == 16'd0);
   assign at_last   = (pos_q.h == 16'(H_TOTAL - 1)) && (pos_q.v == 16'(V_TOTAL - 1));
   assign g_exp     = pos_q.v[7:0] + pos_q.f + pos_q.h[7:0];
   assign mismatch  = (R_i != pos_q.h[7:0]) || (B_i != pos_q.v[7:0]) || (G_i != g_exp);
   assign sof_clean = SOF_i && (R_i == 8'd0) && (B_i == 8'd0);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      exp_d    = exp_q;
      fe_d     = fe_q;
      fe_inc   = fe_q;
      errcnt_d = errcnt_q;
      err_d    = 1'b0;
      sync_d   = 1'b0;
      done_d   = 1'b0;
      acquire  = 1'b0;

      case (state_q)
         HUNT: begin
            if (sof_clean) acquire = 1'b1;
            else if (SOF_i) sync_d = 1'b1;
         end
         default: begin
            if (SOF_i && !at_origin) begin
               // Misplaced SOF: drop out and re-evaluate it as a HUNT SOF.
               sync_d  = 1'b1;
               state_d = HUNT;
               acquire = sof_clean;
            end else if (!SOF_i && at_origin && state_q == ACQ) begin
               sync_d  = 1'b1;
               state_d = HUNT;
            end else begin
               // Missing SOF in LOCK only flags; the counters flywheel on.
               sync_d = !SOF_i && at_origin;
               exp_d  = pos_q;
               pos_d  = advance(pos_q);
               if (mismatch) begin
                  err_d = 1'b1;
                  if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
               end
               if (state_q == ACQ) begin
                  if (mismatch) begin
                     state_d = HUNT;
                  end else if (at_last) begin
                     done_d  = 1'b1;
                     state_d = LOCK;
                  end
               end else begin
                  if (mismatch && fe_q < FE_W'(ERR_LIMIT)) fe_inc = fe_q + 1'b1;
                  fe_d = fe_inc;
                  if (at_last) begin
                     done_d = 1'b1;
                     fe_d   = '0;
                     if (fe_inc >= FE_W'(ERR_LIMIT)) state_d = HUNT;
                  end
               end
            end
         end
      endcase

      // A clean SOF pins this pixel to (0,0) with the field taken from G.
      if (acquire) begin
         state_d = ACQ;
         exp_d   = '{h: 16'd0, v: 16'd0, f: G_i};
         pos_d   = advance(exp_d);
         fe_d    = '0;
      end
   end

   // NOTE: reset is synchronous and checked before the enable so it lands on
   // the next edge even while CK_EE_i is low; state uses non-blocking updates.
   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         state_q  <= HUNT;
         pos_q    <= '0;
         exp_q    <= '0;
         fe_q     <= '0;
         errcnt_q <= '0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
         sync_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (CK_EE_i) begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         exp_q    <= exp_d;
         fe_q     <= fe_d;
         errcnt_q <= errcnt_d;
         lock_q   <= (state_d == LOCK);
         err_q    <= err_d;
         sync_q   <= sync_d;
         done_q   <= done_d;
      end
   end

   assign LOCK_o       = lock_q;
   assign ERR_o        = err_q;
   assign SYNC_ERR_o   = sync_q;
   assign FIELD_DONE_o = done_q;
   assign ERRCNT_o     = errcnt_q;
   assign HEXP_o       = exp_q.h;
   assign VEXP_o       = exp_q.v;
   assign FEXP_o       = exp_q.f;

endmodule

// File: tb/tb_test_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_test_pattern_checker
//
// Self-checking bench for test_pattern_checker on a reduced 16x4 raster
// (64 pixels per field) with ERR_LIMIT = 63, so a locked field can carry up to
// 62 errors and still keep lock, which keeps the saturation run short.
// A directed vector table covers reset, HUNT/ACQ entry and early drop-outs;
// hand-written sequences cover lock, error limit, sync faults, enable gaps,
// counter saturation and mid-lock reset.
// -----------------------------------------------------------------------------
module tb_test_pattern_checker;

   localparam int HT = 16;
   localparam int VT = 4;
   localparam int EL = 63;
   localparam int FIELD = HT * VT;

   logic        CK_i = 1'b0;
   logic        RST_i = 1'b1;
   logic        CK_EE_i = 1'b0;
   logic        SOF_i = 1'b0;
   logic [7:0]  R_i = '0, G_i = '0, B_i = '0;
   logic        LOCK_o, ERR_o, SYNC_ERR_o, FIELD_DONE_o;
   logic [15:0] ERRCNT_o, HEXP_o, VEXP_o;
   logic [7:0]  FEXP_o;

   int checks = 0;
   int errors = 0;
   bit gap = 1'b0;

   test_pattern_checker #(.H_TOTAL(HT), .V_TOTAL(VT), .ERR_LIMIT(EL)) dut (
      .CK_i(CK_i), .RST_i(RST_i), .CK_EE_i(CK_EE_i), .SOF_i(SOF_i),
      .R_i(R_i), .G_i(G_i), .B_i(B_i),
      .LOCK_o(LOCK_o), .ERR_o(ERR_o), .SYNC_ERR_o(SYNC_ERR_o),
      .FIELD_DONE_o(FIELD_DONE_o), .ERRCNT_o(ERRCNT_o),
      .HEXP_o(HEXP_o), .VEXP_o(VEXP_o), .FEXP_o(FEXP_o)
   );

   always #5 CK_i = ~CK_i;

   typedef struct packed {
      logic        rst, ce, sof;
      logic [7:0]  r, g, b;
      logic        lock, err, sync, done;
      logic [15:0] errcnt, hexp, vexp;
      logic [7:0]  fexp;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one clock with the given inputs and sample 1 time unit after the edge.
   task automatic drive(input logic ce, input logic sof, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
      CK_EE_i = ce; SOF_i = sof; R_i = r; G_i = g; B_i = b;
      @(posedge CK_i);
      #1;
   endtask

   // Send pattern pixel number idx of field f; corrupt flips G bit 0.
   // With gap set, each pixel is followed by a disabled cycle of garbage.
   task automatic px(input int idx, input logic [7:0] f, input bit corrupt);
      logic [7:0] h, v, g;
      h = 8'(idx % HT);
      v = 8'(idx / HT);
      g = (v + f + h) ^ {7'd0, corrupt};
      drive(1'b1, idx == 0, h, g, v);
      if (gap) drive(1'b0, 1'b1, 8'hA5, 8'h5A, 8'h3C);
   endtask

   task automatic run(input logic [7:0] f, input int lo, input int hi,
                      input int c_lo, input int c_hi);
      for (int i = lo; i <= hi; i++) px(i, f, (i >= c_lo) && (i <= c_hi));
   endtask

   task automatic check_all(input string tag, input logic lock, input logic err,
                            input logic sync, input logic done, input logic [15:0] errcnt,
                            input logic [15:0] hexp, input logic [15:0] vexp,
                            input logic [7:0] fexp);
      check({tag, ".lock"},   16'(LOCK_o),       16'(lock));
      check({tag, ".err"},    16'(ERR_o),        16'(err));
      check({tag, ".sync"},   16'(SYNC_ERR_o),   16'(sync));
      check({tag, ".done"},   16'(FIELD_DONE_o), 16'(done));
      check({tag, ".errcnt"}, ERRCNT_o,          errcnt);
      check({tag, ".hexp"},   HEXP_o,            hexp);
      check({tag, ".vexp"},   VEXP_o,            vexp);
      check({tag, ".fexp"},   16'(FEXP_o),       16'(fexp));
   endtask

   initial begin
      int drops;
      logic [7:0] fld;

      //          rst  ce   sof  r      g      b      lk   er   sy   dn   errcnt hexp   vexp   fexp
      vecs[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,16'd0, 16'd0, 16'd0, 8'h00}; // reset
      vecs[1]  = '{1'b0,1'b1,1'b0,8'h03,8'h07,8'h02,1'b0,1'b0,1'b0,1'b0,16'd0, 16'd0, 16'd0, 8'h00}; // HUNT ignores data
      vecs[2]  = '{1'b0,1'b1,1'b1,8'h01,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,16'd0, 16'd0, 16'd0, 8'h00}; // SOF with R!=0
      vecs[3]  = '{1'b0,1'b0,1'b1,8'h00,8'h09,8'h00,1'b0,1'b0,1'b1,1'b0,16'd0, 16'd0, 16'd0, 8'h00}; // disabled: hold
      vecs[4]  = '{1'b0,1'b1,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,16'd0, 16'd0, 16'd0, 8'h00}; // pulse clears
      vecs[5]  = '{1'b0,1'b1,1'b1,8'h00,8'h05,8'h00,1'b0,1'b0,1'b0,1'b0,16'd0, 16'd0, 16'd0, 8'h05}; // acquire F=5
      vecs[6]  = '{1'b0,1'b1,1'b0,8'h01,8'h06,8'h00,1'b0,1'b0,1'b0,1'b0,16'd0, 16'd1, 16'd0, 8'h05}; // clean (1,0)
      vecs[7]  = '{1'b0,1'b0,1'b0,8'hAA,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,16'd0, 16'd1, 16'd0, 8'h05}; // disabled garbage
      vecs[8]  = '{1'b0,1'b1,1'b0,8'h02,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,16'd1, 16'd2, 16'd0, 8'h05}; // G bad -> HUNT
      vecs[9]  = '{1'b0,1'b1,1'b0,8'h03,8'h08,8'h00,1'b0,1'b0,1'b0,1'b0,16'd1, 16'd2, 16'd0, 8'h05}; // HUNT, no compare
      vecs[10] = '{1'b0,1'b1,1'b1,8'h00,8'h05,8'h00,1'b0,1'b0,1'b0,1'b0,16'd1, 16'd0, 16'd0, 8'h05}; // reacquire
      vecs[11] = '{1'b0,1'b1,1'b0,8'h11,8'h06,8'h00,1'b0,1'b1,1'b0,1'b0,16'd2, 16'd1, 16'd0, 8'h05}; // R bad
      vecs[12] = '{1'b0,1'b1,1'b1,8'h00,8'h05,8'h00,1'b0,1'b0,1'b0,1'b0,16'd2, 16'd0, 16'd0, 8'h05}; // reacquire
      vecs[13] = '{1'b0,1'b1,1'b0,8'h01,8'h06,8'h01,1'b0,1'b1,1'b0,1'b0,16'd3, 16'd1, 16'd0, 8'h05}; // B bad
      vecs[14] = '{1'b0,1'b1,1'b1,8'h00,8'h05,8'h00,1'b0,1'b0,1'b0,1'b0,16'd3, 16'd0, 16'd0, 8'h05}; // ACQ, next (1,0)

      for (int i = 0; i < 15; i++) begin
         RST_i = vecs[i].rst;
         drive(vecs[i].ce, vecs[i].sof, vecs[i].r, vecs[i].g, vecs[i].b);
         check_all($sformatf("vec%0d", i), vecs[i].lock, vecs[i].err, vecs[i].sync,
                   vecs[i].done, vecs[i].errcnt, vecs[i].hexp, vecs[i].vexp, vecs[i].fexp);
      end

      // Finish the first clean field: lock rises exactly on its last pixel.
      run(8'h05, 1, FIELD - 2, -1, -1);
      check("acq_pre_last.lock", 16'(LOCK_o), 16'd0);
      check("acq_pre_last.done", 16'(FIELD_DONE_o), 16'd0);
      px(FIELD - 1, 8'h05, 1'b0);
      check_all("acq_last", 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd15, 16'd3, 8'h05);

      // Field wrap: F advances 5 -> 6; a single flipped G bit keeps lock.
      px(0, 8'h06, 1'b0);
      check_all("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd0, 16'd0, 8'h06);
      run(8'h06, 1, 41, -1, -1);
      px(42, 8'h06, 1'b1);
      check_all("flip_g0", 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd10, 16'd2, 8'h06);
      px(43, 8'h06, 1'b0);
      check("flip_next.err", 16'(ERR_o), 16'd0);
      run(8'h06, 44, FIELD - 1, -1, -1);
      check("f6_end.done", 16'(FIELD_DONE_o), 16'd1);
      check("f6_end.lock", 16'(LOCK_o), 16'd1);

      // ERR_LIMIT errors in one locked field: lock drops at field end.
      run(8'h07, 0, FIELD - 2, 1, FIELD - 1);
      check("lim_pre.lock", 16'(LOCK_o), 16'd1);
      check("lim_pre.errcnt", ERRCNT_o, 16'd66);
      px(FIELD - 1, 8'h07, 1'b1);
      check_all("lim_end", 1'b0, 1'b1, 1'b0, 1'b1, 16'd67, 16'd15, 16'd3, 8'h07);
      px(0, 8'h08, 1'b0);
      check_all("reacq", 1'b0, 1'b0, 1'b0, 1'b0, 16'd67, 16'd0, 16'd0, 8'h08);
      run(8'h08, 1, FIELD - 1, -1, -1);
      check("relock.lock", 16'(LOCK_o), 16'd1);
      check("relock.done", 16'(FIELD_DONE_o), 16'd1);

      // Misplaced SOF at (12,1) with R=B=0: sync error and immediate ACQ.
      run(8'h09, 0, 27, -1, -1);
      drive(1'b1, 1'b1, 8'h00, 8'h40, 8'h00);
      check_all("sof_mid", 1'b0, 1'b0, 1'b1, 1'b0, 16'd67, 16'd0, 16'd0, 8'h40);
      px(1, 8'h40, 1'b0);
      check_all("sof_mid_next", 1'b0, 1'b0, 1'b0, 1'b0, 16'd67, 16'd1, 16'd0, 8'h40);
      run(8'h40, 2, FIELD - 1, -1, -1);
      check("sof_relock.lock", 16'(LOCK_o), 16'd1);

      // Missing SOF at (0,0) in LOCK: sync error only, flywheel keeps lock.
      drive(1'b1, 1'b0, 8'h00, 8'h41, 8'h00);
      check_all("no_sof", 1'b1, 1'b0, 1'b1, 1'b0, 16'd67, 16'd0, 16'd0, 8'h41);
      px(1, 8'h41, 1'b0);
      check("no_sof_next.sync", 16'(SYNC_ERR_o), 16'd0);
      run(8'h41, 2, FIELD - 1, -1, -1);
      check("no_sof_end.lock", 16'(LOCK_o), 16'd1);

      // Enable toggling 1-0-1-0: garbage in disabled cycles is ignored and
      // every output is sampled after the disabled cycle, so it must hold.
      gap = 1'b1;
      px(0, 8'h42, 1'b0);
      check("gap_sof.fexp", 16'(FEXP_o), 16'h42);
      drive(1'b1, 1'b1, 8'h00, 8'h50, 8'h00);
      drive(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
      check_all("gap_resync", 1'b0, 1'b0, 1'b1, 1'b0, 16'd67, 16'd0, 16'd0, 8'h50);
      run(8'h50, 1, FIELD - 2, -1, -1);
      check_all("gap_pre_last", 1'b0, 1'b0, 1'b0, 1'b0, 16'd67, 16'd14, 16'd3, 8'h50);
      px(FIELD - 1, 8'h50, 1'b0);
      check_all("gap_last", 1'b1, 1'b0, 1'b0, 1'b1, 16'd67, 16'd15, 16'd3, 8'h50);
      px(0, 8'h51, 1'b0);
      check("gap_wrap.done", 16'(FIELD_DONE_o), 16'd0);
      check("gap_wrap.fexp", 16'(FEXP_o), 16'h51);
      gap = 1'b0;

      // Saturation: EL-1 errors per field keeps lock; 67 + 1056*62 > 65535.
      run(8'h51, 1, FIELD - 1, -1, -1);
      fld = 8'h52;
      drops = 0;
      for (int n = 0; n < 1056; n++) begin
         run(fld, 0, FIELD - 1, 1, EL - 1);
         if (LOCK_o !== 1'b1) drops++;
         fld = fld + 8'd1;
      end
      check("sat.lock_drops", 16'(drops), 16'd0);
      check("sat.errcnt", ERRCNT_o, 16'hFFFF);
      px(0, fld, 1'b1);
      check_all("sat_more", 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'd0, 16'd0, fld);

      // Reset mid-field in LOCK, with the enable low: everything clears.
      run(fld, 1, 20, -1, -1);
      RST_i = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      check_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
      RST_i = 1'b0;
      drive(1'b1, 1'b0, 8'd21, 8'h00, 8'd1);
      check_all("rst_hunt", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
